// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state encoding and channel limit for fifo_drain_arbiter
package fifo_arb_pkg;

  localparam int MAX_CH = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_READ    = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_OUTPUT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_READ    = ST_READ,
    S_CAPTURE = ST_CAPTURE,
    S_OUTPUT  = ST_OUTPUT
  } arb_state_e;

endpackage

// File: rtl/fifo_drain_arbiter_rr_picker.sv
// rtl/fifo_drain_arbiter_rr_picker.sv - combinational round-robin search starting after the last winner
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
)(
  input  logic [NUM_CH-1:0] i_Elig,
  input  logic [CH_W-1:0]   i_Last,
  output logic              o_Found,
  output logic [CH_W-1:0]   o_Idx
);

  logic [CH_W-1:0] cand;

  // Walk from farthest to nearest so the nearest eligible channel after i_Last is the final write.
  always_comb begin
    o_Found = 1'b0;
    o_Idx   = '0;
    cand    = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = CH_W'((int'(i_Last) + i) % NUM_CH);
      if (i_Elig[cand]) begin
        o_Found = 1'b1;
        o_Idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// rtl/fifo_drain_arbiter.sv - round-robin reader draining standard-mode FIFOs into one valid/ready sink
module fifo_drain_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int WIDTH  = 8,
  localparam int CH_W   = $clog2(NUM_CH)
)(
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic [NUM_CH-1:0]       i_ChMask,
  input  logic [NUM_CH-1:0]       i_Empty,
  output logic [NUM_CH-1:0]       o_RdEn,
  input  logic [NUM_CH*WIDTH-1:0] i_RdData,
  output logic                    o_Valid,
  input  logic                    i_Ready,
  output logic [WIDTH-1:0]        o_Data,
  output logic [CH_W-1:0]         o_Ch,
  output logic                    o_Busy
);

  arb_state_e        state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [NUM_CH-1:0] rd_en_q, rd_en_d;
  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  data_q, data_d;

  logic [NUM_CH-1:0] elig;
  logic              found;
  logic [CH_W-1:0]   pick_idx;
  logic              arb;
  logic [WIDTH-1:0]  rd_word [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign rd_word[k] = i_RdData[k*WIDTH +: WIDTH];
  end

  assign elig = i_ChMask & ~i_Empty;

  rr_picker #(.NUM_CH(NUM_CH)) u_picker (
    .i_Elig  (elig),
    .i_Last  (last_q),
    .o_Found (found),
    .o_Idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    ch_d    = ch_q;
    rd_en_d = '0;
    valid_d = valid_q;
    data_d  = data_q;
    arb     = 1'b0;
    case (state_q)
      S_IDLE:    arb = 1'b1;
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: begin
        data_d  = rd_word[grant_q];
        ch_d    = grant_q;
        valid_d = 1'b1;
        state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (i_Ready) begin
          valid_d = 1'b0;
          arb     = 1'b1;
        end
      end
      default:   state_d = S_IDLE;
    endcase
    // Only IDLE and an accepted OUTPUT arbitrate, so the just-read channel's empty flag has settled.
    if (arb) begin
      if (found) begin
        grant_d = pick_idx;
        last_d  = pick_idx;
        rd_en_d = NUM_CH'(1) << pick_idx;
        state_d = S_READ;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= CH_W'(NUM_CH - 1);
      ch_q    <= '0;
      rd_en_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      ch_q    <= ch_d;
      rd_en_q <= rd_en_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_RdEn  = rd_en_q;
  assign o_Valid = valid_q;
  assign o_Data  = data_q;
  assign o_Ch    = ch_q;
  assign o_Busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// tb/tb_fifo_drain_arbiter.sv - randomized and directed bench for fifo_drain_arbiter
module tb_fifo_drain_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] mask = '0;
  logic [N-1:0] empty = '1;
  logic [N-1:0] rden;
  logic [N*W-1:0] rdata = '0;
  logic         valid;
  logic         ready = 1'b0;
  logic [W-1:0] data;
  logic [CW-1:0] ch;
  logic         busy;

  always #5 clk = ~clk;

  fifo_drain_arbiter #(.NUM_CH(N), .WIDTH(W)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_ChMask(mask), .i_Empty(empty), .o_RdEn(rden),
    .i_RdData(rdata), .o_Valid(valid), .i_Ready(ready), .o_Data(data), .o_Ch(ch), .o_Busy(busy)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // FIFO contents and bookkeeping
  logic [W-1:0] fq [N][$];
  int           rd_cnt [N];
  bit           uflow = 1'b0;
  typedef struct { int c; logic [W-1:0] d; int t; } acc_t;
  acc_t         acc_q [$];

  // Transaction-level reference: a grant is a scheduled read; its word appears two edges later.
  bit           m_valid = 1'b0;
  bit           m_infl  = 1'b0;
  int           m_age   = 0;
  int           m_last  = N - 1;
  int           m_ich   = 0;
  int           m_ch    = 0;
  logic [W-1:0] m_iword = '0;
  logic [W-1:0] m_data  = '0;
  logic [N-1:0] m_rden  = '0;
  logic [N-1:0] e_vec;
  logic [N-1:0] nxt_empty;
  bit           m_arb;

  always @(posedge clk) begin
    cyc++;
    e_vec = mask & ~empty;
    chk("rden_on_empty", 32'(rden & empty), 32'd0);
    if (!rst && valid && ready) acc_q.push_back('{int'(ch), data, cyc});
    if (rst) begin
      m_valid = 1'b0; m_infl = 1'b0; m_rden = '0; m_last = N - 1;
    end else begin
      m_arb  = 1'b0;
      m_rden = '0;
      if (m_infl) begin
        m_age++;
        if (m_age == 2) begin
          m_infl = 1'b0; m_valid = 1'b1; m_data = m_iword; m_ch = m_ich;
        end
      end else if (!m_valid) begin
        m_arb = 1'b1;
      end else if (ready) begin
        m_valid = 1'b0; m_arb = 1'b1;
      end
      if (m_arb) begin
        for (int i = 1; i <= N; i++) begin
          if (e_vec[(m_last + i) % N]) begin
            m_ich   = (m_last + i) % N;
            m_rden[m_ich] = 1'b1;
            m_infl  = 1'b1;
            m_age   = 0;
            m_iword = fq[m_ich][0];
            m_last  = m_ich;
            break;
          end
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      if (rden[k]) begin
        if (fq[k].size() == 0) uflow = 1'b1;
        else begin
          rdata[k*W +: W] <= fq[k].pop_front();
          rd_cnt[k]++;
        end
      end
      nxt_empty[k] = (fq[k].size() == 0);
    end
    empty <= nxt_empty;
  end

  always @(posedge clk) begin
    #1;
    chk("rden", 32'(rden), 32'(m_rden));
    chk("rden_onehot0", 32'($onehot0(rden)), 32'd1);
    chk("valid", 32'(valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_valid || m_infl));
    if (m_valid) begin
      chk("data", 32'(data), 32'(m_data));
      chk("ch", 32'(ch), 32'(m_ch));
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_acc(int n, int budget);
    int b = 0;
    while (acc_q.size() < n && b < budget) begin tick(); b++; end
    chk("accept_timeout", 32'(acc_q.size() >= n), 32'd1);
  endtask

  task automatic wait_valid(int budget);
    int b = 0;
    while (!valid && b < budget) begin tick(); b++; end
    chk("valid_timeout", 32'(valid), 32'd1);
  endtask

  task automatic drain();
    int b = 0;
    bit done = 1'b0;
    mask = '1; ready = 1'b1; rst = 1'b0;
    while (!done && b < 400) begin
      tick(); b++;
      done = (empty == '1) && !busy && (fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size() == 0);
    end
    chk("drain_timeout", 32'(done), 32'd1);
  endtask

  int base;
  logic [W-1:0] w2 [N][2];

  initial begin
    rst = 1'b1;
    tick(3);
    chk("reset_rden", 32'(rden), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_data", 32'(data), 32'd0);
    chk("reset_ch", 32'(ch), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // single channel, two words, back-to-back
    mask = 4'hF; ready = 1'b1; acc_q.delete(); base = rd_cnt[2];
    fq[2].push_back(8'hA5); fq[2].push_back(8'h3C);
    wait_acc(2, 40);
    if (acc_q.size() >= 2) begin
      chk("t1_ch0", 32'(acc_q[0].c), 32'd2);
      chk("t1_d0", 32'(acc_q[0].d), 32'hA5);
      chk("t1_ch1", 32'(acc_q[1].c), 32'd2);
      chk("t1_d1", 32'(acc_q[1].d), 32'h3C);
      chk("t1_spacing", 32'(acc_q[1].t - acc_q[0].t), 32'd3);
    end
    tick(3);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_reads", 32'(rd_cnt[2] - base), 32'd2);

    // all channels, two words each: order 0,1,2,3,0,1,2,3
    drain(); do_reset(); acc_q.delete();
    for (int k = 0; k < N; k++)
      for (int j = 0; j < 2; j++) begin
        w2[k][j] = W'($urandom);
        fq[k].push_back(w2[k][j]);
      end
    wait_acc(8, 80);
    if (acc_q.size() >= 8)
      for (int i = 0; i < 8; i++) begin
        chk("t2_ch", 32'(acc_q[i].c), 32'(i % 4));
        chk("t2_data", 32'(acc_q[i].d), 32'(w2[i % 4][i / 4]));
      end

    // masked channel is skipped until enabled
    drain(); do_reset(); acc_q.delete();
    mask = 4'b1101; base = rd_cnt[1];
    fq[1].push_back(8'h5A);
    tick(10);
    chk("t3_masked_reads", 32'(rd_cnt[1] - base), 32'd0);
    chk("t3_masked_busy", 32'(busy), 32'd0);
    mask = 4'hF;
    wait_acc(1, 10);
    if (acc_q.size() >= 1) begin
      chk("t3_ch", 32'(acc_q[0].c), 32'd1);
      chk("t3_data", 32'(acc_q[0].d), 32'h5A);
    end

    // backpressure holds the word and blocks further reads
    drain(); do_reset(); acc_q.delete();
    ready = 1'b0;
    fq[0].push_back(8'h11); fq[1].push_back(8'h22);
    wait_valid(10);
    base = rd_cnt[0] + rd_cnt[1];
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_valid", 32'(valid), 32'd1);
      chk("t4_hold_data", 32'(data), 32'h11);
      chk("t4_hold_ch", 32'(ch), 32'd0);
    end
    chk("t4_no_reads", 32'(rd_cnt[0] + rd_cnt[1] - base), 32'd0);
    ready = 1'b1;
    wait_acc(2, 20);
    if (acc_q.size() >= 2) chk("t4_second", 32'(acc_q[1].d), 32'h22);

    // reset during READ and during OUTPUT
    drain(); do_reset(); acc_q.delete();
    fq[1].push_back(8'h31); fq[1].push_back(8'h32);
    fq[3].push_back(8'h71); fq[3].push_back(8'h72);
    base = 0;
    while (rden == '0 && base < 10) begin tick(); base++; end
    chk("t5_first_grant", 32'(rden), 32'b0010);
    rst = 1'b1; tick();
    chk("t5_rst_read_rden", 32'(rden), 32'd0);
    chk("t5_rst_read_valid", 32'(valid), 32'd0);
    chk("t5_rst_read_busy", 32'(busy), 32'd0);
    rst = 1'b0; acc_q.delete();
    wait_acc(1, 20);
    if (acc_q.size() >= 1) begin
      chk("t5_after_rst_ch", 32'(acc_q[0].c), 32'd1);
      chk("t5_after_rst_data", 32'(acc_q[0].d), 32'h32);
    end
    ready = 1'b0;
    wait_valid(10);
    chk("t5_out_ch", 32'(ch), 32'd3);
    chk("t5_out_data", 32'(data), 32'h71);
    fq[2].push_back(8'h55);
    tick(2);
    rst = 1'b1; tick();
    chk("t5_rst_out_rden", 32'(rden), 32'd0);
    chk("t5_rst_out_valid", 32'(valid), 32'd0);
    chk("t5_rst_out_busy", 32'(busy), 32'd0);
    rst = 1'b0; ready = 1'b1; acc_q.delete();
    wait_acc(1, 20);
    if (acc_q.size() >= 1) begin
      chk("t5_lowest_ch", 32'(acc_q[0].c), 32'd2);
      chk("t5_lowest_data", 32'(acc_q[0].d), 32'h55);
    end

    // randomized traffic, mask and backpressure against the model
    drain(); do_reset();
    for (int i = 0; i < 3000; i++) begin
      ready = ($urandom_range(3) != 0);
      if (i % 50 == 0) mask = N'($urandom);
      if ($urandom_range(2) == 0) begin
        int k;
        k = $urandom_range(N - 1);
        if (fq[k].size() < 6) fq[k].push_back(W'($urandom));
      end
      rst = ($urandom_range(399) == 0);
      tick();
    end
    rst = 1'b0;

    // lone single-word channel: exactly one read, no underflow
    drain(); do_reset(); acc_q.delete();
    uflow = 1'b0; base = rd_cnt[3];
    fq[3].push_back(8'hC3);
    tick(25);
    chk("t6_reads", 32'(rd_cnt[3] - base), 32'd1);
    chk("t6_accepted", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() >= 1) chk("t6_data", 32'(acc_q[0].d), 32'hC3);
    chk("t6_underflow", 32'(uflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fifo_drain_arbiter.md
# fifo_drain_arbiter

Round-robin read scheduler that drains up to NUM_CH independent standard-mode (non-first-word-fall-through) FIFO instances into one shared consumer over a valid/ready handshake. It sits between the per-channel FIFOs, such as per-peripheral TX queues, and a single downstream sink such as a bus-write engine or a serializer. It issues exactly one read strobe per word, captures the returned word, and tags it with its source channel. Because it is the only reader of each FIFO, it never reads an empty FIFO.

## Interface
Parameters:
- NUM_CH, 4, number of FIFO channels drained (2..16)
- WIDTH, 8, data width of each FIFO and of o_Data
- CH_W, $clog2(NUM_CH), width of the channel tag (derived localparam; not overridable)

Ports:
- i_Clk  in  1  single clock; all logic is posedge
- i_Rst  in  1  reset, synchronous, active-high
- i_ChMask  in  NUM_CH  per-channel enable; 0 excludes the channel from arbitration
- i_Empty  in  NUM_CH  o_Empty of each FIFO
- o_RdEn  out  NUM_CH  i_RdEn of each FIFO; at most one bit high (one-hot or zero)
- i_RdData  in  NUM_CH*WIDTH  o_RdData of each FIFO, flattened; channel k occupies bits [k*WIDTH +: WIDTH]
- o_Valid  out  1  o_Data/o_Ch hold a word
- i_Ready  in  1  consumer accepts the word when o_Valid && i_Ready at a posedge
- o_Data  out  WIDTH  captured word
- o_Ch  out  CH_W  source channel of o_Data
- o_Busy  out  1  FSM is not in IDLE

## Operation
- FSM states:
  - IDLE: choose a channel per the round-robin rule. If any channel is eligible, latch the winner in r_Grant, move r_Last to the winner, go to READ. Otherwise stay in IDLE.
  - READ: o_RdEn[r_Grant]=1 for exactly this one cycle, then go to CAPTURE.
  - CAPTURE: o_Data <= i_RdData[r_Grant], o_Ch <= r_Grant, o_Valid <= 1, then go to OUTPUT.
  - OUTPUT: hold o_Valid, o_Data and o_Ch stable until i_Ready. On acceptance, o_Valid <= 0. In the same cycle, re-arbitrate exactly as in IDLE: go to READ with the new grant, or go to IDLE if no channel is eligible.
- Eligibility: i_ChMask[k] && !i_Empty[k].
- Round-robin rule: search channels r_Last+1, r_Last+2, … modulo NUM_CH; the first eligible channel wins. A channel that just won has lowest priority next time.
- Changes to i_ChMask or i_Empty after a grant do not abort the transaction; the word in flight is always delivered.
- o_RdEn is never asserted for a channel whose i_Empty is 1 at that posedge. Consequently the FIFOs' underflow flags never set because of this block.
- i_Empty of the channel just read is not used for arbitration until at least 2 cycles after its o_RdEn. The FIFO count settles one cycle after the read, so a stale "not empty" flag is never acted on.
- Reset values: o_RdEn=0, o_Valid=0, o_Data=0, o_Ch=0, o_Busy=0, state=IDLE, r_Grant=0, r_Last=NUM_CH-1, so channel 0 has first priority after reset.

## Timing
- Per-word sequence: arbitration decision at edge T. o_RdEn high during cycle T..T+1. The FIFO updates o_RdData at edge T+1. Capture happens at edge T+2, so o_Valid is high from T+2.
- Latency: 2 cycles from grant to o_Valid.
- Throughput: with i_Ready held high, one word every 3 cycles (READ, CAPTURE, OUTPUT), with no IDLE cycle between words.
- Backpressure: o_Valid, o_Data and o_Ch must not change while o_Valid && !i_Ready.
- Reset mid-transaction: all outputs take their reset values at the next edge.
  - A word whose o_RdEn already fired is discarded; the FIFOs have no reset and are not rewound.
  - If reset occurs during READ, o_RdEn drops at the reset edge.
- Simultaneous acceptance and eligibility: OUTPUT goes directly to READ, and o_RdEn rises in the cycle after acceptance.
- Single eligible channel: it is re-granted back-to-back.

## Structure
- Shared package fifo_arb_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_READ=2'd1, ST_CAPTURE=2'd2, ST_OUTPUT=2'd3
  - the maximum NUM_CH constant (16)
- Sub-module rr_picker: combinational. Inputs are the eligibility vector and r_Last. Outputs are o_Found and o_Idx (CH_W bits). It is instantiated once and used by both IDLE and the OUTPUT re-arbitration path.
- Top level contains the FSM, r_Grant/r_Last, the output registers and the i_RdData mux.

## Test plan
- Reset, then i_ChMask=4'hF with only channel 2 holding the words 8'hA5 and 8'h3C, i_Ready=1 → o_RdEn=4'b0100 for one cycle, twice. Outputs are (8'hA5, ch 2) then (8'h3C, ch 2), 3 cycles apart; then IDLE, o_Busy=0.
- All 4 channels holding 2 words each, i_Ready=1 → o_Ch sequence 0,1,2,3,0,1,2,3. Eight o_RdEn pulses total, never two bits high at once.
- Channel 1 holds a word but i_ChMask=4'b1101 → no o_RdEn[1]. Then set the mask to 4'hF → channel 1 is served within 1 cycle of the next IDLE arbitration.
- Hold i_Ready=0 for 10 cycles after o_Valid rises → o_Data and o_Ch stay stable and no further o_RdEn occurs. Release i_Ready → the next o_RdEn follows in the next cycle.
- Assert i_Rst during READ and again during OUTPUT → at the following edge o_RdEn=0, o_Valid=0, o_Busy=0. The next grant after release goes to the lowest-numbered eligible channel.
- Channel 3 holds exactly 1 word and is the only eligible channel → exactly one read; no second o_RdEn on a stale i_Empty; the FIFO's o_UnderFlow stays 0.
